// File: rtl/ntt_addr_scheduler.sv
// Address sequencer for a 512-point mixed-radix NTT over a 4-bank memory map.
// Four radix-4 stages, then one radix-2 stage, with a drain gap between stages.
module ntt_addr_scheduler #(
  parameter int ADDR_W    = 9,
  parameter int CNT_W     = 7,
  parameter int R4_STAGES = 4,
  parameter int GAP_CYC   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              radix2,
  output logic [ADDR_W-1:0] addr_0,
  output logic [ADDR_W-1:0] addr_1,
  output logic [ADDR_W-1:0] addr_2,
  output logic [ADDR_W-1:0] addr_3,
  output logic              addr_valid,
  output logic              map_valid,
  output logic [CNT_W-1:0]  tw_exp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = '1;
  localparam logic [3:0] GAP_LAST =
    4'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
  localparam logic [2:0] LAST_STAGE = 3'(R4_STAGES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        stage_q, stage_d;
  logic [3:0]        gap_q, gap_d;
  logic              issue;
  logic              adv;

  logic [3:0][ADDR_W-1:0] lane_d;
  logic [CNT_W-1:0]       tw_d;
  logic [ADDR_W-1:0]      hi;
  logic [CNT_W-1:0]       lo;

  logic [3:0][ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]       tw_q;
  logic                   av_q;
  logic                   mv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          issue = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            gap_d = '0;
            if (GAP_CYC == 0) adv = 1'b1;
            else state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) adv = 1'b1;
        else gap_d = gap_q + 4'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Stage advance is shared by the gap expiry and the zero-gap path
    if (adv) begin
      if (stage_q == LAST_STAGE) begin
        state_d = S_DONE;
      end else begin
        state_d = S_RUN;
        stage_d = stage_q + 3'd1;
        cnt_d   = '0;
      end
    end
  end

  // Radix-4 stage s: the lane index is spliced in above the low
  // (CNT_W-2s) counter bits; every shift is a per-stage constant.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = ADDR_W'({cnt_q, 2'(i)});
    end
    tw_d = '0;
    hi   = '0;
    lo   = '0;
    for (int s = 0; s < R4_STAGES; s++) begin
      if (stage_q == 3'(s)) begin
        lo = cnt_q & CNT_W'((1 << (CNT_W - 2*s)) - 1);
        hi = ADDR_W'(cnt_q >> (CNT_W - 2*s))
             << (CNT_W - 2*s + 2);
        for (int i = 0; i < 4; i++) begin
          lane_d[i] = hi
                    | (ADDR_W'(i) << (CNT_W - 2*s))
                    | ADDR_W'(lo);
        end
        tw_d = lo << (2*s);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      tw_q   <= '0;
      av_q   <= 1'b0;
      mv_q   <= 1'b0;
    end else begin
      av_q <= issue;
      mv_q <= av_q;
      if (issue) begin
        addr_q <= lane_d;
        tw_q   <= tw_d;
      end
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_GAP);
  assign done       = (state_q == S_DONE);
  assign stage      = stage_q;
  assign radix2     = (stage_q == LAST_STAGE);
  assign addr_0     = addr_q[0];
  assign addr_1     = addr_q[1];
  assign addr_2     = addr_q[2];
  assign addr_3     = addr_q[3];
  assign addr_valid = av_q;
  assign map_valid  = mv_q;
  assign tw_exp     = tw_q;

endmodule
